// File: rtl/rand_sched.sv
// Round-robin random-number scheduler: serves each requester once per frame with a value
// drawn from an external LFSR by rejection sampling against the requester's bound.
`timescale 1ns/1ps
module rand_sched #(
  parameter int NREQ      = 4,
  parameter int W         = 10,
  parameter int MAX_TRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] bound,
  output logic            rng_step,
  input  logic [W-1:0]    rng_value,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    rand_o,
  output logic            rand_valid,
  output logic            fail,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {StIdle, StStep, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [W-1:0]    bnd_q, bnd_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [NREQ-1:0] served_q, served_d;

  logic [NREQ-1:0] elig;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [W-1:0]    pick_bound;
  logic            go_done, go_ok;
  logic [W-1:0]    go_val;
  logic [NREQ-1:0] gnt_d;

  assign elig = req & ~served_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + 1 + k) % NREQ;
      if (!pick_found && elig[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  assign pick_bound = bound[pick_idx*W +: W];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    bnd_d   = bnd_q;
    tries_d = tries_q;
    go_done = 1'b0;
    go_ok   = 1'b0;
    go_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          win_d   = pick_idx;
          bnd_d   = pick_bound;
          tries_d = '0;
          // An empty range can never be satisfied, so skip sampling entirely.
          if (pick_bound == '0) begin
            state_d = StDone;
            go_done = 1'b1;
          end else begin
            state_d = StStep;
          end
        end
      end
      StStep: begin
        tries_d = tries_q + 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        if (rng_value < bnd_q) begin
          state_d = StDone;
          go_done = 1'b1;
          go_ok   = 1'b1;
          go_val  = rng_value;
        end else if (tries_q < TW'(MAX_TRIES)) begin
          state_d = StStep;
        end else begin
          state_d = StDone;
          go_done = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A frame clears the mask first; a grant completing in the same cycle still records its winner.
  always_comb begin
    served_d = frame ? '0 : served_q;
    ptr_d    = ptr_q;
    if (state_q == StDone) begin
      served_d[win_q] = 1'b1;
      ptr_d           = win_q;
    end
  end

  always_comb begin
    gnt_d = '0;
    if (go_done) gnt_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IW'(NREQ - 1);
      win_q      <= '0;
      bnd_q      <= '0;
      tries_q    <= '0;
      served_q   <= '0;
      rng_step   <= 1'b0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      fail       <= 1'b0;
      busy       <= 1'b0;
      rand_o     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      bnd_q      <= bnd_d;
      tries_q    <= tries_d;
      served_q   <= served_d;
      rng_step   <= (state_d == StStep);
      gnt        <= gnt_d;
      rand_valid <= go_done;
      fail       <= go_done & ~go_ok;
      busy       <= (state_d != StIdle);
      if (go_done) rand_o <= go_val;
    end
  end

endmodule

// File: tb/tb_rand_sched.sv
// Scoreboard bench for rand_sched: directed scenarios push expected grants, a monitor checks them.
`timescale 1ns/1ps
module tb_rand_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic [3:0]  req = '0;
  logic [39:0] bound = '0;
  logic        rng_step;
  logic [9:0]  rng_value = '0;
  logic [3:0]  gnt;
  logic [9:0]  rand_o;
  logic        rand_valid;
  logic        fail;
  logic        busy;

  rand_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame),
    .req        (req),
    .bound      (bound),
    .rng_step   (rng_step),
    .rng_value  (rng_value),
    .gnt        (gnt),
    .rand_o     (rand_o),
    .rand_valid (rand_valid),
    .fail       (fail),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       fail;
    logic [9:0] val;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] rq[$];
  logic [9:0] rng_default = 10'd5;
  int         cyc = 0;
  int         step_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc++;

  // LFSR stand-in: a new value appears the cycle after each step pulse.
  always @(negedge clk) begin
    if (rng_step) begin
      step_cnt++;
      rng_value = (rq.size() > 0) ? rq.pop_front() : rng_default;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rand_valid || gnt != 4'b0 || fail)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b valid=%b fail=%b rand=%0d at cyc %0d, want none",
                 gnt, rand_valid, fail, rand_o, cyc);
      end else begin
        e = sb.pop_front();
        if (gnt != e.gnt || fail != e.fail || rand_o != e.val || !rand_valid || cyc != e.cyc) begin
          errors++;
          $display("FAIL grant: got gnt=%b fail=%b rand=%0d valid=%b cyc=%0d, want gnt=%b fail=%b rand=%0d valid=1 cyc=%0d",
                   gnt, fail, rand_o, rand_valid, cyc, e.gnt, e.fail, e.val, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input logic [3:0] g, input logic f, input logic [9:0] v, input int c);
    exp_t e;
    e.gnt = g; e.fail = f; e.val = v; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending grants, want 0", name, sb.size());
      sb.delete();
    end
    repeat (4) tick();
  endtask

  task automatic set_bound(input int i, input logic [9:0] v);
    bound[i*10 +: 10] = v;
  endtask

  task automatic clear_frame();
    req = '0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    req = '0;
    rq.delete();
    repeat (2) tick();
    check(name, int'({rng_step, gnt, rand_valid, fail, busy, rand_o}), 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int c;
    repeat (2) tick();
    do_reset("reset_outputs");

    // Single requester, in-range first draw.
    set_bound(0, 10'd617);
    rq.push_back(10'd100);
    step_cnt = 0;
    c = cyc;
    req = 4'b0001;
    expect_gnt(4'b0001, 1'b0, 10'd100, c + 3);
    tick();
    check("step_at_n1", int'(rng_step), 1);
    wait_empty("basic");
    check("basic_steps", step_cnt, 1);
    check("rand_hold", int'(rand_o), 100);

    // All requesters, full-range bounds: order 0..3, then again after a frame.
    do_reset("reset_again");
    for (int i = 0; i < 4; i++) set_bound(i, 10'd1023);
    rng_default = 10'd5;
    c = cyc;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) expect_gnt(4'(1 << i), 1'b0, 10'd5, c + 3 + 4 * i);
    wait_empty("rr_round1");
    repeat (10) tick();
    check("idle_after_round", int'(busy), 0);
    c = cyc;
    frame = 1'b1;
    for (int i = 0; i < 4; i++) expect_gnt(4'(1 << i), 1'b0, 10'd5, c + 4 + 4 * i);
    tick();
    frame = 1'b0;
    wait_empty("rr_round2");

    // Two rejections before an accepted value.
    clear_frame();
    set_bound(2, 10'd617);
    rq.push_back(10'd700);
    rq.push_back(10'd650);
    rq.push_back(10'd300);
    step_cnt = 0;
    c = cyc;
    req = 4'b0100;
    expect_gnt(4'b0100, 1'b0, 10'd300, c + 7);
    wait_empty("reject2");
    check("reject2_steps", step_cnt, 3);

    // Zero bound fails immediately without sampling.
    clear_frame();
    set_bound(3, 10'd0);
    step_cnt = 0;
    c = cyc;
    req = 4'b1000;
    expect_gnt(4'b1000, 1'b1, 10'd0, c + 1);
    wait_empty("zero_bound");
    check("zero_bound_steps", step_cnt, 0);

    // Exhausted tries; req dropped mid-service is still granted.
    clear_frame();
    set_bound(1, 10'd5);
    rng_default = 10'd1000;
    step_cnt = 0;
    c = cyc;
    req = 4'b0010;
    expect_gnt(4'b0010, 1'b1, 10'd0, c + 33);
    repeat (10) tick();
    check("busy_mid", int'(busy), 1);
    req = 4'b0000;
    wait_empty("exhaust");
    check("exhaust_steps", step_cnt, 16);

    // Frame coincident with DONE keeps only the winner's served bit.
    do_reset("reset_frame_test");
    set_bound(2, 10'd1023);
    rng_default = 10'd5;
    c = cyc;
    req = 4'b0100;
    expect_gnt(4'b0100, 1'b0, 10'd5, c + 3);
    wait_empty("pre_frame");
    set_bound(0, 10'd617);
    set_bound(1, 10'd1023);
    set_bound(3, 10'd1023);
    rq.push_back(10'd100);
    c = cyc;
    req = 4'b0001;
    expect_gnt(4'b0001, 1'b0, 10'd100, c + 3);
    repeat (3) tick();
    frame = 1'b1;
    req = 4'b1111;
    for (int i = 1; i < 4; i++) expect_gnt(4'(1 << i), 1'b0, 10'd5, c + 7 + 4 * (i - 1));
    tick();
    frame = 1'b0;
    wait_empty("frame_done");
    repeat (10) tick();

    // Reset during CHECK abandons the grant.
    clear_frame();
    set_bound(0, 10'd617);
    rq.push_back(10'd100);
    req = 4'b0001;
    repeat (2) tick();
    check("busy_in_check", int'(busy), 1);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    check("reset_mid_outputs", int'({rng_step, gnt, rand_valid, fail, busy, rand_o}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rq.delete();
    repeat (12) tick();
    check("no_grant_after_reset", int'(rand_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_sched.md
RAND_SCHED -- requirements
Module: rand_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter W, default 10: random value width.
REQ-003 Parameter MAX_TRIES, default 16: rejection-sampling attempt limit per grant.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert and active-low.
REQ-006 frame  input  1: one-cycle start-of-frame pulse.
REQ-007 req  input  NREQ: per-requester level request, held until granted.
REQ-008 bound  input  NREQ*W: requester i exclusive upper bound at bits [i*W +: W].
REQ-009 rng_step  output  1: one-cycle pulse commanding the external LFSR to advance.
REQ-010 rng_value  input  W: external LFSR value, valid the cycle after rng_step.
REQ-011 gnt  output  NREQ: one-hot, one-cycle pulse naming the served requester.
REQ-012 rand_o  output  W: result delivered to the served requester.
REQ-013 rand_valid  output  1: one-cycle pulse, coincident with gnt.
REQ-014 fail  output  1: one-cycle pulse, coincident with gnt, when no in-range value was found.
REQ-015 busy  output  1: high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, STEP, CHECK, DONE; all outputs registered.
REQ-017 Eligible requester: req[i]=1 and served[i]=0; served is an NREQ-bit per-frame mask.
REQ-018 IDLE: when any requester is eligible, pick winner by round-robin starting at index ptr+1 mod NREQ, latch index and bound, clear try counter, go STEP; otherwise stay in IDLE.
REQ-019 STEP: drive rng_step=1 for exactly one cycle, increment try counter, go CHECK.
REQ-020 CHECK: sample rng_value; if rng_value < latched bound, latch it into the result and go DONE with success.
REQ-021 CHECK: otherwise, if try counter < MAX_TRIES go STEP; if try counter = MAX_TRIES go DONE with failure and result 0.
REQ-022 Latched bound = 0: go directly from IDLE to DONE with failure, rand_o=0, no rng_step issued.
REQ-023 DONE: pulse gnt[winner]=1 and rand_valid=1, plus fail=1 on failure; set served[winner]; set ptr=winner; go IDLE.
REQ-024 rand_o holds its last value until the next DONE.
REQ-025 Best-case latency: eligible in IDLE at cycle N -> rng_step at N+1 -> compare at N+2 -> gnt/rand_valid at N+3.
REQ-026 Each rejected try adds 2 cycles; worst case is 3 + 2*(MAX_TRIES-1) cycles from IDLE to DONE.
REQ-027 frame clears served to all-zero; frame does not abort an in-progress grant.
REQ-028 frame and DONE in the same cycle: the mask is cleared, then the winner's served bit is set.
REQ-029 Comparison is unsigned W-bit; bound = 2^W-1 rejects only the value 2^W-1.
REQ-030 A requester dropping req mid-service is still granted; a req change after IDLE does not alter the winner.
REQ-031 At most one requester is granted per DONE; gnt is all-zero outside DONE.

Reset
REQ-032 While rst_n=0: state=IDLE, ptr=NREQ-1 (so requester 0 has first priority), served=0, try counter=0.
REQ-033 While rst_n=0: rng_step=0, gnt=0, rand_valid=0, fail=0, busy=0, rand_o=0.
REQ-034 Reset asserted mid-operation abandons the grant immediately; no gnt is issued for it after release.

Verification
REQ-035 After reset, req=4'b0001, bound0=617, rng_value=100 after the step -> rng_step at N+1, gnt=4'b0001, rand_valid=1, rand_o=100 at N+3, fail=0.
REQ-036 req=4'b1111 and all bounds 1023 -> grants in order 0,1,2,3, each once; afterwards stays IDLE until frame, then serves 0,1,2,3 again.
REQ-037 bound2=617, rng_value sequence 700, 650, 300 -> 3 rng_step pulses, gnt=4'b0100 with rand_o=300 at the 7th cycle after IDLE detection.
REQ-038 bound1=5, rng_value always 1000, MAX_TRIES=16 -> exactly 16 rng_step pulses, then gnt=4'b0010, fail=1, rand_o=0.
REQ-039 bound3=0 -> gnt=4'b1000, fail=1 at N+1, with no rng_step.
REQ-040 Reset pulse during CHECK -> all outputs 0 immediately; no gnt after release; frame coincident with DONE leaves only the winner's served bit set.
